lbp_host: RTL
=============

Name: lbp_host

Overview:
- Memory-side responder for the LBP engine's gray/LBP interface. It owns the 128x128 gray image and the 128x128 LBP result image.
- Three phases:
  - Load: it is loaded with a raster pixel stream.
  - Serve: it serves the engine's gray reads and captures the engine's LBP writes.
  - Dump: after the engine signals finish, it streams the LBP image out.
- It sits between the image source/sink and the LBP engine, and replaces the behavioural memories used today.

Parameters:
- IMG_W, 128, image width in pixels (power of two)
- IMG_H, 128, image height in pixels
- AW, 14, address width, log2(IMG_W*IMG_H)
- DW, 8, pixel width

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- load_valid  in  1  a source pixel is present on load_data
- load_data  in  DW  source gray pixel, raster order from address 0
- load_ready  out  1  block accepts a load pixel this cycle
- gray_ready  out  1  gray image available to the engine
- gray_req  in  1  engine read request
- gray_addr  in  AW  engine read address
- gray_data  out  DW  gray pixel at gray_addr
- lbp_valid  in  1  engine write strobe
- lbp_addr  in  AW  engine write address
- lbp_data  in  DW  engine LBP result
- finish  in  1  engine reports that all interior pixels are written
- dump_valid  out  1  dump_data/dump_addr are valid
- dump_ready  in  1  sink accepts the dump beat
- dump_addr  out  AW  LBP image address of the current beat
- dump_data  out  DW  LBP pixel at dump_addr
- wr_count  out  AW  number of LBP writes accepted in SERVE
- err  out  1  sticky protocol error flag
- done  out  1  dump complete

Behaviour:
- States: LOAD, SERVE, DUMP, DONE. Reset enters LOAD.
- Reset values: load_ready=1, gray_ready=0, gray_data=0, dump_valid=0, dump_addr=0, wr_count=0, err=0, done=0, internal load counter=0.
- Reset does not clear either memory array.
- Reset mid-operation aborts the current phase and returns to LOAD with all counters zero.
- LOAD:
  - On load_valid && load_ready: write gray_mem[cnt] <= load_data and lbp_mem[cnt] <= 0 in the same cycle, then cnt++. This guarantees border pixels read back as 0.
  - After the beat at cnt = IMG_W*IMG_H-1 is accepted: go to SERVE. load_ready drops to 0 on the next cycle and stays 0 until reset.
- SERVE:
  - gray_ready=1, registered; it rises the cycle after the last load beat.
  - gray_data = gray_mem[gray_addr] combinationally when gray_req && gray_ready, else 0. Data is valid in the same cycle as the address, so the engine samples it at the next rising edge.
  - On lbp_valid: lbp_mem[lbp_addr] <= lbp_data and wr_count++.
  - wr_count saturates at all-ones; it never wraps.
  - A write to a border address (row 0, row IMG_H-1, col 0, col IMG_W-1) is still performed and sets err.
  - finish sampled high: go to DUMP next cycle. An lbp_valid coincident with finish is written and counted. gray_ready drops to 0.
- DUMP:
  - dump_valid=1 and dump_data=lbp_mem[dump_addr], registered and held stable while !dump_ready.
  - On each dump_valid && dump_ready, advance dump_addr by 1.
  - The beat at dump_addr = IMG_W*IMG_H-1 accepted: go to DONE.
- DONE: done=1, dump_valid=0. Holds until reset.
- err sets (sticky until reset) on any of:
  - lbp_valid outside SERVE; such a write is ignored and not counted;
  - gray_req while gray_ready=0;
  - load_valid outside LOAD; such a beat is ignored;
  - a border-address write.
- Addresses are unsigned AW bits: row = addr[AW-1:log2(IMG_W)], col = addr[log2(IMG_W)-1:0].

Test Plan:
- Reset, load ramp pixel[i]=i[7:0] over 16384 beats -> load_ready falls after the last beat, gray_ready=1 the next cycle, gray_addr=129 with gray_req gives gray_data=0x81 in the same cycle.
- Engine model writes all 15876 interior addresses (129..16254, col 1..126) then raises finish -> wr_count=15876, err=0, state DUMP.
- Dump with dump_ready toggled 1,0,1 -> dump_data held during the stall. Address 0 returns 0x00, address 129 returns the written value. done=1 after 16384 accepted beats.
- lbp_valid at lbp_addr=5 (row 0) with data 0xFF -> err=1, lbp_mem[5]=0xFF visible in dump, wr_count incremented.
- lbp_valid and finish in the same cycle at addr 16254 -> the write lands, and dump beat 16254 shows it.
- Assert reset during DUMP at dump_addr=100 -> all outputs return to reset values immediately. A reload plus re-serve produces a fresh dump starting at address 0.

Source files
------------

// File: rtl/lbp_host_if.sv
// Bundle of the load, engine gray/LBP and dump signals shared between lbp_host and its neighbours.
interface lbp_host_if #(
    parameter int AW = 14,
    parameter int DW = 8
);
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_ready;
    logic          gray_ready;
    logic          gray_req;
    logic [AW-1:0] gray_addr;
    logic [DW-1:0] gray_data;
    logic          lbp_valid;
    logic [AW-1:0] lbp_addr;
    logic [DW-1:0] lbp_data;
    logic          finish;
    logic          dump_valid;
    logic          dump_ready;
    logic [AW-1:0] dump_addr;
    logic [DW-1:0] dump_data;
    logic [AW-1:0] wr_count;
    logic          err;
    logic          done;

    modport slave (
        input  load_valid, load_data, gray_req, gray_addr,
        input  lbp_valid, lbp_addr, lbp_data, finish, dump_ready,
        output load_ready, gray_ready, gray_data, dump_valid,
        output dump_addr, dump_data, wr_count, err, done
    );

    modport master (
        output load_valid, load_data, gray_req, gray_addr,
        output lbp_valid, lbp_addr, lbp_data, finish, dump_ready,
        input  load_ready, gray_ready, gray_data, dump_valid,
        input  dump_addr, dump_data, wr_count, err, done
    );
endinterface

// File: rtl/lbp_host.sv
// Memory-side responder for the LBP engine: loads the gray image, serves engine reads,
// captures LBP writes and streams the LBP image out.
//
// state   | meaning
// S_LOAD  | accepting raster gray pixels, clearing the LBP image alongside
// S_SERVE | engine reads gray pixels and writes LBP results
// S_DUMP  | streaming the LBP image to the sink
// S_DONE  | dump finished, idle until reset
module lbp_host #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int AW    = 14,
    parameter int DW    = 8
) (
    input logic       clk,
    input logic       reset,
    lbp_host_if.slave bus
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int CW   = $clog2(IMG_W);
    localparam logic [AW-1:0]    LAST_ADDR = AW'(NPIX - 1);
    localparam logic [AW-CW-1:0] LAST_ROW  = (AW - CW)'(IMG_H - 1);

    typedef enum logic [1:0] {S_LOAD, S_SERVE, S_DUMP, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wr_count_q, wr_count_d;
    logic          err_q, err_d;
    logic [AW-1:0] dump_addr_q, dump_addr_d;
    logic [DW-1:0] dump_data_q, dump_data_d;

    logic [DW-1:0] gray_mem [NPIX];
    logic [DW-1:0] lbp_mem  [NPIX];

    logic          gray_we;
    logic          lbp_we;
    logic [AW-1:0] lbp_waddr;
    logic [DW-1:0] lbp_wdata;
    logic [AW-1:0] dump_next;
    logic [AW-CW-1:0] lbp_row;
    logic [CW-1:0]    lbp_col;
    logic             lbp_border;

    assign dump_next  = dump_addr_q + 1'b1;
    assign lbp_row    = bus.lbp_addr[AW-1:CW];
    assign lbp_col    = bus.lbp_addr[CW-1:0];
    assign lbp_border = (lbp_row == '0) || (lbp_row == LAST_ROW) ||
                        (lbp_col == '0) || (lbp_col == '1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_count_d  = wr_count_q;
        err_d       = err_q;
        dump_addr_d = dump_addr_q;
        dump_data_d = dump_data_q;
        gray_we     = 1'b0;
        lbp_we      = 1'b0;
        lbp_waddr   = '0;
        lbp_wdata   = '0;

        case (state_q)
            S_LOAD: begin
                if (bus.load_valid) begin
                    gray_we   = 1'b1;
                    lbp_we    = 1'b1;
                    lbp_waddr = cnt_q;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) state_d = S_SERVE;
                end
            end
            S_SERVE: begin
                if (bus.lbp_valid) begin
                    lbp_we    = 1'b1;
                    lbp_waddr = bus.lbp_addr;
                    lbp_wdata = bus.lbp_data;
                    if (wr_count_q != '1) wr_count_d = wr_count_q + 1'b1;
                    if (lbp_border) err_d = 1'b1;
                end
                if (bus.finish) begin
                    state_d     = S_DUMP;
                    dump_addr_d = '0;
                    // forward a coincident write to address 0 so the first beat is current
                    dump_data_d = (bus.lbp_valid && bus.lbp_addr == '0) ? bus.lbp_data : lbp_mem[0];
                end
            end
            S_DUMP: begin
                if (bus.dump_ready) begin
                    dump_addr_d = dump_next;
                    dump_data_d = lbp_mem[dump_next];
                    if (dump_addr_q == LAST_ADDR) state_d = S_DONE;
                end
            end
            default: ;
        endcase

        if (bus.lbp_valid && state_q != S_SERVE) err_d = 1'b1;
        if (bus.gray_req && state_q != S_SERVE)  err_d = 1'b1;
        if (bus.load_valid && state_q != S_LOAD) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_LOAD;
            cnt_q       <= '0;
            wr_count_q  <= '0;
            err_q       <= 1'b0;
            dump_addr_q <= '0;
            dump_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_count_q  <= wr_count_d;
            err_q       <= err_d;
            dump_addr_q <= dump_addr_d;
            dump_data_q <= dump_data_d;
        end
    end

    // image arrays survive reset; a reload rewrites both of them
    always_ff @(posedge clk) begin
        if (gray_we) gray_mem[cnt_q] <= bus.load_data;
        if (lbp_we)  lbp_mem[lbp_waddr] <= lbp_wdata;
    end

    assign bus.load_ready = (state_q == S_LOAD);
    assign bus.gray_ready = (state_q == S_SERVE);
    assign bus.gray_data  = (bus.gray_req && state_q == S_SERVE) ? gray_mem[bus.gray_addr] : '0;
    assign bus.dump_valid = (state_q == S_DUMP);
    assign bus.dump_addr  = dump_addr_q;
    assign bus.dump_data  = dump_data_q;
    assign bus.wr_count   = wr_count_q;
    assign bus.err        = err_q;
    assign bus.done       = (state_q == S_DONE);
endmodule
